// File: rtl/vote_collector_pkg.sv
// Shared definitions for the vote collector: voter count and session FSM encoding.
package vote_collector_pkg;

   localparam int NUM_VOTERS = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OPEN  = 2'd1,
      ST_CLOSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/vote_collector_key_sync_edge.sv
// One push-button input: 2-flop synchroniser followed by a rising-edge detector.
module key_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= key;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/vote_collector.sv
// Five-voter ballot collector: timed session, one locked vote per voter,
// registered ballot with a one-cycle valid pulse plus local yes count / pass flag.
module vote_collector
   import vote_collector_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [NUM_VOTERS-1:0] key_yes,
   input  logic [NUM_VOTERS-1:0] key_no,
   output logic                  busy,
   output logic [NUM_VOTERS-1:0] voted,
   output logic [NUM_VOTERS-1:0] ballot,
   output logic                  ballot_valid,
   output logic [2:0]            yes_cnt,
   output logic                  pass,
   output logic                  timeout_flag
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        timer;
   logic [NUM_VOTERS-1:0]   yes_rise;
   logic [NUM_VOTERS-1:0]   no_rise;
   logic [NUM_VOTERS-1:0]   accept;
   logic [NUM_VOTERS-1:0]   voted_nxt;
   logic [NUM_VOTERS-1:0]   ballot_nxt;
   logic [2:0]              cnt_nxt;
   logic                    all_voted;
   logic                    timer_end;

   function automatic logic [2:0] popcount(input logic [NUM_VOTERS-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
         n = n + 3'(v[i]);
      end
      return n;
   endfunction

   for (genvar g = 0; g < NUM_VOTERS; g++) begin : g_keys
      key_sync_edge u_yes (
         .clk   (clk),
         .rst_n (rst_n),
         .key   (key_yes[g]),
         .rise  (yes_rise[g])
      );
      key_sync_edge u_no (
         .clk   (clk),
         .rst_n (rst_n),
         .key   (key_no[g]),
         .rise  (no_rise[g])
      );
   end

   // Exactly one of yes/no must rise for a still-unvoted voter; simultaneous edges cancel.
   always_comb begin
      accept = '0;
      if (state == ST_OPEN) begin
         accept = (yes_rise ^ no_rise) & ~voted;
      end
      voted_nxt  = voted | accept;
      ballot_nxt = (ballot & ~accept) | (yes_rise & accept);
      cnt_nxt    = popcount(ballot_nxt);
      all_voted  = &voted_nxt;
      timer_end  = (timer == CNT_W'(TIMEOUT_CYC - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_OPEN;
         ST_OPEN:  if (all_voted || timer_end) state_nxt = ST_CLOSE;
         ST_CLOSE: state_nxt = ST_DONE;
         ST_DONE:  if (start) state_nxt = ST_OPEN;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy         = (state == ST_OPEN) || (state == ST_CLOSE);
      ballot_valid = (state == ST_CLOSE);
   end

   // Count and pass are captured on the edge entering CLOSE so they are already
   // stable for the whole ballot_valid cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer        <= '0;
         voted        <= '0;
         ballot       <= '0;
         yes_cnt      <= '0;
         pass         <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  timer        <= '0;
                  voted        <= '0;
                  ballot       <= '0;
                  yes_cnt      <= '0;
                  pass         <= 1'b0;
                  timeout_flag <= 1'b0;
               end
            end
            ST_OPEN: begin
               timer  <= timer + CNT_W'(1);
               voted  <= voted_nxt;
               ballot <= ballot_nxt;
               if (state_nxt == ST_CLOSE) begin
                  yes_cnt      <= cnt_nxt;
                  pass         <= (cnt_nxt >= 3'd3);
                  timeout_flag <= ~all_voted;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vote_collector.sv
// Scoreboard bench for vote_collector: sessions push expected ballots, a monitor
// pops and compares them on every ballot_valid pulse.
module tb_vote_collector;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [4:0] key_yes;
   logic [4:0] key_no;
   logic       busy;
   logic [4:0] voted;
   logic [4:0] ballot;
   logic       ballot_valid;
   logic [2:0] yes_cnt;
   logic       pass;
   logic       timeout_flag;

   typedef struct {
      logic [4:0] ballot;
      logic [4:0] voted;
      logic [2:0] cnt;
      logic       pass;
      logic       to;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   seen   = 0;
   int   cyc    = 0;
   int   e0     = 0;
   int   base   = 0;

   vote_collector #(.TIMEOUT_CYC(TO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .key_yes      (key_yes),
      .key_no       (key_no),
      .busy         (busy),
      .voted        (voted),
      .ballot       (ballot),
      .ballot_valid (ballot_valid),
      .yes_cnt      (yes_cnt),
      .pass         (pass),
      .timeout_flag (timeout_flag)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (ballot_valid) begin
         exp_t e;
         seen++;
         chk("valid_expected", int'(sbq.size() > 0), 1);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_ballot", int'(ballot), int'(e.ballot));
            chk("sb_voted", int'(voted), int'(e.voted));
            chk("sb_yes_cnt", int'(yes_cnt), int'(e.cnt));
            chk("sb_pass", int'(pass), int'(e.pass));
            chk("sb_timeout_flag", int'(timeout_flag), int'(e.to));
            chk("sb_busy", int'(busy), 1);
            if (e.cyc >= 0) chk("sb_close_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      e0 = cyc;
   endtask

   task automatic press(input logic [4:0] y, input logic [4:0] n);
      key_yes = key_yes | y;
      key_no  = key_no | n;
      tick(2);
      key_yes = key_yes & ~y;
      key_no  = key_no & ~n;
      tick(1);
   endtask

   task automatic push(input logic [4:0] b, input logic [4:0] v, input logic [2:0] c,
                       input logic p, input logic t, input int cy);
      exp_t e;
      e.ballot = b; e.voted = v; e.cnt = c; e.pass = p; e.to = t; e.cyc = cy;
      sbq.push_back(e);
   endtask

   task automatic wait_close(input string name);
      for (int i = 0; i < 40 && seen == base; i++) tick(1);
      chk(name, seen - base, 1);
      tick(2);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; key_yes = '0; key_no = '0;
      for (int i = 0; i < 3; i++) begin
         key_yes = 5'($urandom);
         key_no  = 5'($urandom);
         tick(1);
      end
      chk("rst_busy", int'(busy), 0);
      chk("rst_voted", int'(voted), 0);
      chk("rst_ballot", int'(ballot), 0);
      chk("rst_valid", int'(ballot_valid), 0);
      chk("rst_cnt_pass_to", int'({yes_cnt, pass, timeout_flag}), 0);
      key_yes = '0; key_no = '0;
      tick(1);
      rst_n = 1'b1;
      tick(3);

      // full vote: yes 0,2,4 / no 1,3
      base = seen;
      do_start();
      push(5'b10101, 5'b11111, 3'd3, 1'b1, 1'b0, -1);
      press(5'b00001, 5'b0); press(5'b0, 5'b00010); press(5'b00100, 5'b0);
      press(5'b0, 5'b01000); press(5'b10000, 5'b0);
      wait_close("full_vote_pulse");
      tick(3);
      chk("done_ballot", int'(ballot), 5'b10101);
      chk("done_cnt", int'(yes_cnt), 3);
      chk("done_pass", int'(pass), 1);
      chk("done_busy", int'(busy), 0);
      press(5'b00010, 5'b0);
      chk("done_key_ignored", int'(ballot), 5'b10101);

      // timeout with a single yes vote
      base = seen;
      do_start();
      push(5'b00010, 5'b00010, 3'd1, 1'b0, 1'b1, e0 + TO);
      press(5'b00010, 5'b0);
      wait_close("timeout_pulse");

      // lock and conflict
      base = seen;
      do_start();
      push(5'b00011, 5'b11111, 3'd2, 1'b0, 1'b0, -1);
      press(5'b00001, 5'b0);
      press(5'b00010, 5'b00001);
      press(5'b01000, 5'b01000);
      chk("conflict_voted", int'(voted), 5'b00011);
      chk("lock_ballot", int'(ballot), 5'b00011);
      press(5'b0, 5'b11100);
      wait_close("lock_pulse");

      // held key before start, stray start mid-session
      key_yes = 5'b00100;
      tick(3);
      base = seen;
      do_start();
      push(5'b00100, 5'b00100, 3'd1, 1'b0, 1'b1, e0 + TO);
      tick(4);
      chk("held_no_vote", int'(voted), 0);
      key_yes = '0;
      tick(2);
      press(5'b00100, 5'b0);
      chk("repress_vote", int'(voted), 5'b00100);
      start = 1'b1; tick(1); start = 1'b0;
      chk("stray_start_busy", int'(busy), 1);
      wait_close("held_pulse");

      // fifth vote lands in the last timer cycle
      base = seen;
      do_start();
      push(5'b10101, 5'b11111, 3'd3, 1'b1, 1'b0, e0 + TO);
      press(5'b00001, 5'b0); press(5'b0, 5'b00010); press(5'b00100, 5'b0);
      press(5'b0, 5'b01000);
      for (int i = 0; i < 40 && cyc < e0 + 17; i++) tick(1);
      chk("boundary_setup_cycle", cyc, e0 + 17);
      press(5'b10000, 5'b0);
      wait_close("boundary_pulse");

      // reset mid-session
      base = seen;
      do_start();
      press(5'b00001, 5'b0);
      chk("pre_reset_voted", int'(voted), 5'b00001);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_voted", int'(voted), 0);
      chk("midrst_ballot", int'(ballot), 0);
      tick(30);
      chk("midrst_no_valid", seen - base, 0);

      chk("sb_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
